// File: rtl/y_event_monitor.sv
// y_event_monitor: synchronises an async pulse line, counts rising edges,
// measures pulse width and serves a four-phase snapshot read handshake.
module y_event_monitor #(
  parameter int CNT_W       = 8,
  parameter int CLR_ON_READ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y_in,
  input  logic             clear,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] rd_width,
  output logic             rd_ovf,
  output logic             y_sync
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SNAP = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic             s1;
  logic             s2;
  logic             y_prev;
  logic             rise;
  logic             fall;
  logic             snap;
  logic             clr_rd;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] last_width;
  logic [1:0]       state;
  logic [1:0]       state_nx;

  assign y_sync = s2;
  assign rise   = s2 & ~y_prev;
  assign fall   = ~s2 & y_prev;
  assign snap   = (state == S_SNAP);
  assign clr_rd = snap && (CLR_ON_READ != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      y_prev <= 1'b0;
    end else begin
      s1     <= y_in;
      s2     <= s1;
      y_prev <= s2;
    end
  end

  // Read-clear wins over a saturating increment; a same-cycle edge restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr_rd) begin
      count <= rise ? ONE : '0;
      ovf   <= 1'b0;
    end else if (rise) begin
      if (count == MAX) begin
        ovf <= 1'b1;
      end else begin
        count <= count + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt       <= '0;
      last_width <= '0;
    end else if (clear) begin
      wcnt       <= '0;
      last_width <= '0;
    end else begin
      if (rise) begin
        wcnt <= ONE;
      end else if (s2 && y_prev && (wcnt != MAX)) begin
        wcnt <= wcnt + ONE;
      end
      if (fall) begin
        last_width <= wcnt;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (rd_req) state_nx = S_SNAP;
      S_SNAP: state_nx = S_ACK;
      S_ACK:  if (!rd_req) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered ack: asserts the cycle after entering ACK, two edges after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rd_ack   <= 1'b0;
      rd_count <= '0;
      rd_width <= '0;
      rd_ovf   <= 1'b0;
    end else begin
      state  <= state_nx;
      rd_ack <= (state == S_ACK) && rd_req;
      if (snap) begin
        rd_count <= count;
        rd_width <= last_width;
        rd_ovf   <= ovf;
      end
    end
  end

endmodule

// File: doc/y_event_monitor.md
Y_EVENT_MONITOR -- requirements
Module: y_event_monitor

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the event counter and the pulse-width register.
REQ-002 Parameter CLR_ON_READ, default 1; 1 = event counter cleared when a read snapshot is taken.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 y_in  input  1  asynchronous YY output of the upstream combinational pattern decoder.
REQ-006 clear  input  1  synchronous clear of count, overflow and width state.
REQ-007 rd_req  input  1  four-phase read request.
REQ-008 rd_ack  output  1  four-phase read acknowledge.
REQ-009 rd_count  output  CNT_W  snapshot of the event counter.
REQ-010 rd_width  output  CNT_W  snapshot of the last completed pulse width.
REQ-011 rd_ovf  output  1  snapshot of the sticky overflow flag.
REQ-012 y_sync  output  1  synchronised y_in.

Function
REQ-013 y_in passes through a 2-flop synchroniser; y_sync is the second flop, so y_sync follows y_in 2 cycles later.
REQ-014 A rising edge is y_sync=1 while its previous-cycle value was 0; a falling edge is the inverse.
REQ-015 On each rising edge, count increments by 1.
  - At 2^CNT_W-1, count holds (saturates) and the sticky ovf is set instead.
REQ-016 Width counter: loads 1 on a rising edge, increments each cycle y_sync stays 1, saturates at 2^CNT_W-1.
REQ-017 On a falling edge, the width counter value is copied to last_width.
  - A pulse still high has no effect on last_width.
REQ-018 clear=1 zeroes count, ovf, the width counter and last_width.
  - Same-cycle clear and edge: clear wins; the edge is discarded.
REQ-019 Read FSM states: IDLE, SNAP, ACK, DONE.
REQ-020 IDLE -> SNAP when rd_req=1; otherwise remain in IDLE.
REQ-021 SNAP (one cycle):
  - rd_count/rd_width/rd_ovf load count/last_width/ovf.
  - If CLR_ON_READ=1, count and ovf clear, except that a rising edge in the same cycle makes count 1.
  - Go to ACK.
REQ-022 ACK: rd_ack=1; stay while rd_req=1; go to DONE when rd_req=0.
REQ-023 DONE: rd_ack=0 for one cycle, then IDLE.
  - A new request is accepted no earlier than 2 cycles after rd_req falls.
REQ-024 rd_count, rd_width and rd_ovf change only in SNAP and are stable from SNAP until the next SNAP.
REQ-025 rd_ack rises exactly 2 cycles after the rising edge of clk that samples rd_req=1 in IDLE.
REQ-026 clear during SNAP/ACK does not alter the snapshot registers and does not disturb the handshake.
REQ-027 Event counting and width measurement continue uninterrupted in all FSM states.

Reset
REQ-028 rst_n=0 immediately forces, independent of clk:
  - both synchroniser flops, the edge history, y_sync, count, ovf, the width counter and last_width to 0;
  - rd_count, rd_width, rd_ovf and rd_ack to 0;
  - the FSM to IDLE.
REQ-029 Reset asserted mid-handshake aborts it: rd_ack=0 at once.
  - After release, the FSM is in IDLE and waits for rd_req=1.
REQ-030 y_in held high through reset release produces no rising edge until y_sync has been observed 0.

Verification
REQ-031 Reset, then y_in pulses 3 times, each 4 cycles high/4 low, then read:
  - rd_count=3, rd_width=4, rd_ovf=0, rd_ack after 2 cycles;
  - an immediate second read gives rd_count=0.
REQ-032 CNT_W=8, 257 pulses, then read -> rd_count=255, rd_ovf=1.
REQ-033 y_in high for 300 cycles then low, then read -> rd_width=255.
REQ-034 clear asserted in the same cycle as a rising edge on y_sync, then read -> rd_count=0.
REQ-035 Rising edge on y_sync in the SNAP cycle with count=5 -> rd_count=5; the following read -> rd_count=1.
REQ-036 rst_n pulsed low while rd_ack=1 -> rd_ack=0 and all outputs 0 immediately; the FSM then serves a new rd_req normally.
